// File: rtl/ulpi_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ulpi_pkg
//  Purpose  : Shared ULPI link types: FSM state encoding, TXCMD prefixes,
//             transfer kinds and requester identifiers.
//  Revision : 1.0 - initial release
// ============================================================================
package ulpi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_TXCMD      = 3'd1,
        ST_REG_WDATA  = 3'd2,
        ST_STOP       = 3'd3,
        ST_RD_TURN    = 3'd4,
        ST_RD_DATA    = 3'd5,
        ST_TX_PAYLOAD = 3'd6,
        ST_PHY_OWN    = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        OP_REGW = 2'd0,
        OP_REGR = 2'd1,
        OP_TX   = 2'd2
    } op_t;

    typedef enum logic {
        GNT_REG = 1'b0,
        GNT_TX  = 1'b1
    } gnt_t;

    localparam logic [1:0] C_PFX_REGW     = 2'b10;
    localparam logic [1:0] C_PFX_REGR     = 2'b11;
    localparam logic [3:0] C_PFX_TRANSMIT = 4'b0100;

endpackage
`default_nettype wire

// File: rtl/ulpi_link_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : ulpi_link_arbiter_if
//  Purpose  : ULPI bus, register-access and packet-transmit signal bundle.
//  Revision : 1.0 - initial release
// ============================================================================
interface ulpi_link_arbiter_if;
    logic       ulpi_dir;
    logic       ulpi_nxt;
    logic [7:0] ulpi_data_in;
    logic [7:0] ulpi_data_out;
    logic       ulpi_data_oe;
    logic       ulpi_stp;

    logic       reg_req;
    logic       reg_wr;
    logic [5:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       reg_done;

    logic       tx_req;
    logic [3:0] tx_pid;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_last;
    logic       tx_ready;
    logic       tx_done;

    logic       err;

    // Link side
    modport master (
        input  ulpi_dir, ulpi_nxt, ulpi_data_in,
        output ulpi_data_out, ulpi_data_oe, ulpi_stp,
        input  reg_req, reg_wr, reg_addr, reg_wdata,
        output reg_rdata, reg_done,
        input  tx_req, tx_pid, tx_data, tx_valid, tx_last,
        output tx_ready, tx_done,
        output err
    );

    // PHY and requester side
    modport slave (
        output ulpi_dir, ulpi_nxt, ulpi_data_in,
        input  ulpi_data_out, ulpi_data_oe, ulpi_stp,
        output reg_req, reg_wr, reg_addr, reg_wdata,
        input  reg_rdata, reg_done,
        output tx_req, tx_pid, tx_data, tx_valid, tx_last,
        input  tx_ready, tx_done,
        input  err
    );
endinterface
`default_nettype wire

// File: rtl/ulpi_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : ulpi_rr_arb
//  Purpose  : Two-requester round-robin grant with a last-grant register.
//  Revision : 1.0 - initial release
// ============================================================================
module ulpi_rr_arb
    import ulpi_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_req_reg,
    input  wire logic i_req_tx,
    input  wire logic i_update,
    input  wire gnt_t i_done_gnt,
    output logic      o_valid,
    output gnt_t      o_gnt
);

    gnt_t r_last;

    // Priority moves only on completion, so aborted attempts keep their turn.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= GNT_TX;
        end else if (i_update) begin
            r_last <= i_done_gnt;
        end
    end

    always_comb begin
        o_valid = i_req_reg | i_req_tx;
        o_gnt   = GNT_TX;
        if (i_req_reg && i_req_tx) begin
            o_gnt = (r_last == GNT_TX) ? GNT_REG : GNT_TX;
        end else if (i_req_reg) begin
            o_gnt = GNT_REG;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ulpi_link_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ulpi_link_arbiter
//  Purpose  : ULPI link-side bus owner sharing the PHY between register
//             accesses and packet transmission.
//  Revision : 1.0 - initial release
// ============================================================================
module ulpi_link_arbiter
    import ulpi_pkg::*;
#(
    parameter int NXT_TIMEOUT = 255
)
(
    input  wire logic          usb_clkin,
    input  wire logic          rst,
    ulpi_link_arbiter_if.master ulpi
);

    localparam int                 C_CNT_W    = $clog2(NXT_TIMEOUT + 1);
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(NXT_TIMEOUT - 1);

    state_t             r_state;
    op_t                r_op;
    gnt_t               r_gnt;
    logic [7:0]         r_txcmd;
    logic [7:0]         r_wdata;
    logic [C_CNT_W-1:0] r_cnt;
    logic               r_turn;
    logic [7:0]         r_reg_rdata;
    logic               r_reg_done;
    logic               r_tx_done;
    logic               r_err;

    logic               w_gnt_valid;
    gnt_t               w_gnt;
    logic               w_tx_ready;
    logic [7:0]         w_data_out;
    logic               w_oe;
    logic               w_stp;

    ulpi_rr_arb u_rr_arb (
        .clk        (usb_clkin),
        .rst        (rst),
        .i_req_reg  (ulpi.reg_req),
        .i_req_tx   (ulpi.tx_req),
        .i_update   (r_reg_done | r_tx_done),
        .i_done_gnt (r_gnt),
        .o_valid    (w_gnt_valid),
        .o_gnt      (w_gnt)
    );

    assign w_tx_ready = (r_state == ST_TX_PAYLOAD) & ulpi.tx_valid
                      & ulpi.ulpi_nxt & ~ulpi.ulpi_dir;

    always_ff @(posedge usb_clkin or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_op        <= OP_REGW;
            r_gnt       <= GNT_TX;
            r_txcmd     <= 8'h00;
            r_wdata     <= 8'h00;
            r_cnt       <= '0;
            r_turn      <= 1'b0;
            r_reg_rdata <= 8'h00;
            r_reg_done  <= 1'b0;
            r_tx_done   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_reg_done <= 1'b0;
            r_tx_done  <= 1'b0;
            r_err      <= 1'b0;
            if (r_state != ST_PHY_OWN) begin
                r_turn <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (ulpi.ulpi_dir) begin
                        r_state <= ST_PHY_OWN;
                    end else if (w_gnt_valid) begin
                        r_gnt   <= w_gnt;
                        r_state <= ST_TXCMD;
                        if (w_gnt == GNT_TX) begin
                            r_op    <= OP_TX;
                            r_txcmd <= {C_PFX_TRANSMIT, ulpi.tx_pid};
                        end else begin
                            r_op    <= ulpi.reg_wr ? OP_REGW : OP_REGR;
                            r_txcmd <= {ulpi.reg_wr ? C_PFX_REGW : C_PFX_REGR,
                                        ulpi.reg_addr};
                            r_wdata <= ulpi.reg_wdata;
                        end
                    end
                end
                ST_TXCMD: begin
                    if (ulpi.ulpi_dir) begin
                        r_state <= ST_PHY_OWN;
                    end else if (ulpi.ulpi_nxt) begin
                        case (r_op)
                            OP_REGW: r_state <= ST_REG_WDATA;
                            OP_REGR: r_state <= ST_RD_TURN;
                            default: r_state <= ST_TX_PAYLOAD;
                        endcase
                    end else if (r_cnt == C_CNT_LAST) begin
                        // Unresponsive PHY: finish the request so the requester is not stuck.
                        r_err      <= 1'b1;
                        r_reg_done <= (r_gnt == GNT_REG);
                        r_tx_done  <= (r_gnt == GNT_TX);
                        r_state    <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + C_CNT_W'(1);
                    end
                end
                ST_REG_WDATA: begin
                    if (ulpi.ulpi_dir) begin
                        r_state <= ST_PHY_OWN;
                    end else if (ulpi.ulpi_nxt) begin
                        r_reg_done <= 1'b1;
                        r_state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    r_state <= ST_IDLE;
                end
                ST_RD_TURN: begin
                    if (ulpi.ulpi_dir) begin
                        r_state <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    r_reg_rdata <= ulpi.ulpi_data_in;
                    r_reg_done  <= 1'b1;
                    r_state     <= ST_PHY_OWN;
                end
                ST_TX_PAYLOAD: begin
                    if (ulpi.ulpi_dir) begin
                        r_state <= ST_PHY_OWN;
                    end else if (w_tx_ready && ulpi.tx_last) begin
                        r_tx_done <= 1'b1;
                        r_state   <= ST_STOP;
                    end
                end
                ST_PHY_OWN: begin
                    // One extra low-DIR cycle before the link may drive again.
                    if (ulpi.ulpi_dir) begin
                        r_turn <= 1'b0;
                    end else if (!r_turn) begin
                        r_turn <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_data_out = 8'h00;
        w_oe       = 1'b0;
        w_stp      = 1'b0;
        case (r_state)
            ST_TXCMD: begin
                w_oe       = 1'b1;
                w_data_out = r_txcmd;
            end
            ST_REG_WDATA: begin
                w_oe       = 1'b1;
                w_data_out = r_wdata;
            end
            ST_STOP: begin
                w_oe  = 1'b1;
                w_stp = 1'b1;
            end
            ST_TX_PAYLOAD: begin
                w_oe = 1'b1;
                if (ulpi.tx_valid) begin
                    w_data_out = ulpi.tx_data;
                end
            end
            default: ;
        endcase
    end

    assign ulpi.ulpi_data_out = w_data_out;
    assign ulpi.ulpi_data_oe  = w_oe;
    assign ulpi.ulpi_stp      = w_stp;
    assign ulpi.reg_rdata     = r_reg_rdata;
    assign ulpi.reg_done      = r_reg_done;
    assign ulpi.tx_ready      = w_tx_ready;
    assign ulpi.tx_done       = r_tx_done;
    assign ulpi.err           = r_err;

endmodule
`default_nettype wire
